usec_timer: RTL

- Programmable down-counting microsecond timer. It sits directly downstream of the 16 MHz to 1 MHz clock divider and consumes that divider's 1 MHz output as a sampled data input, not as a clock.
- Synchronises the 1 MHz signal into the 16 MHz `clk` domain and detects its rising edges to form single-cycle ticks.
- Decrements a loadable count every PRESCALE ticks and raises a sticky interrupt on expiry, with optional auto-reload. Used by the CPU for delays and periodic events.

---
 rtl/usec_timer_if.sv | 26 ++
 rtl/usec_timer.sv | 98 +++++++++
 2 files changed

// File: rtl/usec_timer_if.sv
// Control/status bundle between the CPU and usec_timer.
//   master (CPU side): drives enable, load, load_value, auto_reload, irq_ack;
//                      observes count, irq, running.
//   slave (timer side): the reverse.
interface usec_timer_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;
  logic             irq_ack;
  logic [WIDTH-1:0] count;
  logic             irq;
  logic             running;

  modport master (
    output enable, load, load_value, auto_reload, irq_ack,
    input  count, irq, running
  );

  modport slave (
    input  enable, load, load_value, auto_reload, irq_ack,
    output count, irq, running
  );
endinterface

// File: rtl/usec_timer.sv
// Programmable down-counting microsecond timer.
// The 1 MHz divider output (tick_in) is sampled as data, synchronised into the clk domain and
// edge-detected into single-cycle ticks. Every PRESCALE ticks the count decrements; reaching the
// end raises a sticky irq and either reloads (auto_reload) or stops in DONE.
// Ports:
//   clk      16 MHz system clock, rising edge
//   rst      synchronous active-low reset
//   tick_in  1 MHz square wave, asynchronous to clk
//   bus      control/status bundle (usec_timer_if.slave)
module usec_timer #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PRESCALE = 1   // legal range 1..256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  usec_timer_if.slave bus
);

  localparam logic [7:0] PsMax = 8'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [7:0]       ps_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             irq_q;
  logic             running_q;
  logic             tick;
  logic             strobe;

  always_comb begin
    tick   = s2_q & ~s3_q;
    // Ticks only count while running and enabled; otherwise they are dropped, not queued.
    strobe = (state_q == StRun) && bus.enable && tick && (ps_q == PsMax);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      ps_q      <= 8'd0;
      count_q   <= '0;
      reload_q  <= '0;
      irq_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      s1_q <= tick_in;
      s2_q <= s1_q;
      s3_q <= s2_q;

      // Ack first so that an expiry in the same cycle overrides it.
      if (bus.irq_ack) begin
        irq_q <= 1'b0;
      end

      if (bus.load) begin
        count_q  <= bus.load_value;
        reload_q <= bus.load_value;
        ps_q     <= 8'd0;
        if (bus.load_value != '0) begin
          state_q   <= StRun;
          running_q <= 1'b1;
        end else begin
          state_q   <= StIdle;
          running_q <= 1'b0;
        end
      end else if ((state_q == StRun) && bus.enable && tick) begin
        if (strobe) begin
          ps_q <= 8'd0;
          if (count_q > WIDTH'(1)) begin
            count_q <= count_q - WIDTH'(1);
          end else if (count_q == WIDTH'(1)) begin
            irq_q <= 1'b1;
            if (bus.auto_reload) begin
              count_q <= reload_q;
            end else begin
              count_q   <= '0;
              state_q   <= StDone;
              running_q <= 1'b0;
            end
          end
        end else begin
          ps_q <= ps_q + 8'd1;
        end
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.irq     = irq_q;
  assign bus.running = running_q;

endmodule
